// File: rtl/pll_mode_pkg.sv
// pll_mode_pkg: shared types and the video clock mode table for pll_mode_ctrl.
//   pll_sel_t   : {idsel, fbdsel, odsel}, already in rPLL dynamic-select encoding
//   pll_state_t : controller states
//   mode_sel()  : mode index -> select triple
package pll_mode_pkg;

    localparam int SEL_W       = 6;
    localparam int TABLE_IDX_W = 2;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } pll_sel_t;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAIL      = 2'd3
    } pll_state_t;

    // The rPLL dynamic IDSEL/FBDSEL ports take 64 minus the divider value.
    function automatic logic [SEL_W-1:0] div_sel(input int unsigned div);
        return SEL_W'(64 - div);
    endfunction

    // The dynamic ODSEL port uses a thermometer-like code per output divider.
    function automatic logic [SEL_W-1:0] odiv_sel(input int unsigned odiv);
        logic [SEL_W-1:0] code;
        case (odiv)
            2:       code = 6'b111111;
            4:       code = 6'b111110;
            8:       code = 6'b111100;
            16:      code = 6'b111000;
            32:      code = 6'b110000;
            48:      code = 6'b101000;
            64:      code = 6'b100000;
            80:      code = 6'b011000;
            96:      code = 6'b010000;
            112:     code = 6'b001000;
            128:     code = 6'b000000;
            default: code = 6'b111111;
        endcase
        return code;
    endfunction

    // Mode table from the 27 MHz reference.
    function automatic pll_sel_t mode_sel(input logic [TABLE_IDX_W-1:0] idx);
        pll_sel_t s;
        case (idx)
            2'd0:    s = pll_sel_t'{idsel: div_sel(4), fbdsel: div_sel(55), odsel: odiv_sel(2)}; // 371.25 MHz
            2'd1:    s = pll_sel_t'{idsel: div_sel(3), fbdsel: div_sel(14), odsel: odiv_sel(4)}; // 126 MHz
            2'd2:    s = pll_sel_t'{idsel: div_sel(1), fbdsel: div_sel(10), odsel: odiv_sel(2)}; // 270 MHz
            default: s = pll_sel_t'{idsel: div_sel(1), fbdsel: div_sel(5),  odsel: odiv_sel(4)}; // 135 MHz
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// cdc_sync2: two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output (2 cycles latency)
module cdc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl: run-time controller for the HDMI rPLL. Programs the dynamic
// selects from the mode table, sequences PLL reset and lock qualification,
// retries on lock timeout and flags failure.
//   clk, reset_n          : 27 MHz reference, async active-low reset
//   mode_req/_valid/_ready: mode request handshake
//   pll_lock              : async LOCK from the rPLL
//   pll_reset             : rPLL RESET
//   idsel/fbdsel/odsel    : rPLL dynamic selects
//   cur_mode              : mode currently programmed
//   clk_ok                : PLL output qualified
//   lost_lock, req_err    : single-cycle event pulses
//   fail                  : retries exhausted
//   dbg_state             : current controller state (pll_state_t encoding)
//
// Handshake: a request is taken on any rising edge where mode_req_valid and
// mode_req_ready are both high. ready is high only in RUN and FAIL; a valid
// held while ready is low is simply not taken and has no effect.
module pll_mode_ctrl
    import pll_mode_pkg::*;
#(
    parameter int NUM_MODES        = 4,
    parameter int MODE_W           = $clog2(NUM_MODES),
    parameter int DEFAULT_MODE     = 0,
    parameter int RESET_HOLD_CYC   = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 1048576,
    parameter int MAX_RETRIES      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              mode_req_valid,
    output logic              mode_req_ready,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        idsel,
    output logic [5:0]        fbdsel,
    output logic [5:0]        odsel,
    output logic [MODE_W-1:0] cur_mode,
    output logic              clk_ok,
    output logic              lost_lock,
    output logic              req_err,
    output logic              fail,
    output logic [1:0]        dbg_state
);

    localparam int HOLD_W   = $clog2(RESET_HOLD_CYC + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic lock_s;

    cdc_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    pll_state_t          state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                low_q, low_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    pll_sel_t            sel_q, sel_d;
    logic                pll_reset_q, pll_reset_d;
    logic                clk_ok_q, clk_ok_d;
    logic                ready_q, ready_d;
    logic                fail_q, fail_d;
    logic                lost_q, lost_d;
    logic                err_q, err_d;

    logic req_take;
    logic req_ok;
    logic enter_hold;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        stable_d   = stable_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        lost_d     = 1'b0;
        err_d      = 1'b0;
        enter_hold = 1'b0;

        req_take = mode_req_valid && ready_q;
        req_ok   = 32'(mode_req) < NUM_MODES;

        // An accepted request outranks every state-driven transition,
        // including a lock loss detected on the same edge.
        if (req_take && req_ok) begin
            mode_d     = mode_req;
            sel_d      = mode_sel(TABLE_IDX_W'(mode_req));
            retry_d    = '0;
            state_d    = ST_HOLD;
            enter_hold = 1'b1;
        end else if (req_take) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_W'(RESET_HOLD_CYC - 1)) begin
                        state_d  = ST_WAIT_LOCK;
                        stable_d = '0;
                        tmo_d    = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        stable_d = '0;
                    end else if (stable_q != STABLE_W'(LOCK_STABLE_CYC)) begin
                        stable_d = stable_q + STABLE_W'(1);
                    end
                    if (tmo_q != TMO_W'(LOCK_TIMEOUT_CYC)) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    // Compare against limit-1 so the transition lands on the
                    // edge where the count reaches its limit.
                    if (lock_s && stable_q == STABLE_W'(LOCK_STABLE_CYC - 1)) begin
                        state_d = ST_RUN;
                    end else if (tmo_q == TMO_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        if (32'(retry_q) < MAX_RETRIES) begin
                            retry_d    = retry_q + RETRY_W'(1);
                            state_d    = ST_HOLD;
                            enter_hold = 1'b1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_RUN: begin
                    // low_q remembers a low sample from the previous cycle, so
                    // a single-cycle dropout is filtered.
                    if (!lock_s && low_q) begin
                        lost_d     = 1'b1;
                        retry_d    = '0;
                        state_d    = ST_HOLD;
                        enter_hold = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (enter_hold) begin
            hold_d = '0;
        end

        low_d       = (state_d == ST_RUN) && !lock_s;
        pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
        clk_ok_d    = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN) || (state_d == ST_FAIL);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            hold_q      <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            low_q       <= 1'b0;
            mode_q      <= MODE_W'(DEFAULT_MODE);
            sel_q       <= mode_sel(TABLE_IDX_W'(DEFAULT_MODE));
            pll_reset_q <= 1'b1;
            clk_ok_q    <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lost_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            low_q       <= low_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            pll_reset_q <= pll_reset_d;
            clk_ok_q    <= clk_ok_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lost_q      <= lost_d;
            err_q       <= err_d;
        end
    end

    assign mode_req_ready = ready_q;
    assign pll_reset      = pll_reset_q;
    assign idsel          = sel_q.idsel;
    assign fbdsel         = sel_q.fbdsel;
    assign odsel          = sel_q.odsel;
    assign cur_mode       = mode_q;
    assign clk_ok         = clk_ok_q;
    assign lost_lock      = lost_q;
    assign req_err        = err_q;
    assign fail           = fail_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// tb_pll_mode_ctrl: directed scenarios plus randomized lock/request traffic,
// checked every cycle against a timestamp-based reference model.
module tb_pll_mode_ctrl;

    localparam int NUM_MODES    = 3;
    localparam int MODE_W       = 2;
    localparam int DEFAULT_MODE = 0;
    localparam int HOLD_CYC     = 4;
    localparam int STABLE       = 8;
    localparam int TIMEOUT      = 64;
    localparam int MAX_RETRIES  = 2;

    localparam int M_HOLD = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_FAIL = 3;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [MODE_W-1:0] mode_req       = '0;
    logic              mode_req_valid = 1'b0;
    logic              pll_lock       = 1'b0;
    logic              mode_req_ready;
    logic              pll_reset;
    logic [5:0]        idsel, fbdsel, odsel;
    logic [MODE_W-1:0] cur_mode;
    logic              clk_ok, lost_lock, req_err, fail;
    logic [1:0]        dbg_state;

    pll_mode_ctrl #(
        .NUM_MODES        (NUM_MODES),
        .DEFAULT_MODE     (DEFAULT_MODE),
        .RESET_HOLD_CYC   (HOLD_CYC),
        .LOCK_STABLE_CYC  (STABLE),
        .LOCK_TIMEOUT_CYC (TIMEOUT),
        .MAX_RETRIES      (MAX_RETRIES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .idsel          (idsel),
        .fbdsel         (fbdsel),
        .odsel          (odsel),
        .cur_mode       (cur_mode),
        .clk_ok         (clk_ok),
        .lost_lock      (lost_lock),
        .req_err        (req_err),
        .fail           (fail),
        .dbg_state      (dbg_state)
    );

    // ---------------- checking ----------------
    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected rPLL selects: 64-div for IDSEL/FBDSEL, ODSEL code for /2 or /4.
    function automatic logic [17:0] exp_sel(input int m);
        case (m)
            0:       return {6'd60, 6'd9,  6'b111111};
            1:       return {6'd61, 6'd50, 6'b111110};
            2:       return {6'd63, 6'd54, 6'b111111};
            default: return {6'd63, 6'd59, 6'b111110};
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Phase timing is tracked with edge timestamps: m_t0 is the edge that
    // entered the phase, m_last0 the last edge that saw a low synchronised lock.
    int m_t, m_st, m_t0, m_last0, m_retries, m_mode;
    bit m_prev_ls, m_lost, m_err;
    bit lq[$];

    task automatic model_reset();
        m_t = 0; m_st = M_HOLD; m_t0 = 0; m_last0 = 0;
        m_retries = 0; m_mode = DEFAULT_MODE;
        m_prev_ls = 1'b0; m_lost = 1'b0; m_err = 1'b0;
        lq.delete();
        lq.push_back(1'b0);
        lq.push_back(1'b0);
    endtask

    task automatic enter(input int s);
        m_st = s;
        m_t0 = m_t;
    endtask

    task automatic model_edge();
        bit ls;
        int since;
        m_t++;
        ls = lq.pop_front();
        lq.push_back(pll_lock);
        if (!ls) m_last0 = m_t;
        m_lost = 1'b0;
        m_err  = 1'b0;
        if (mode_req_valid && (m_st == M_RUN || m_st == M_FAIL)) begin
            if (int'(mode_req) < NUM_MODES) begin
                m_mode = int'(mode_req);
                m_retries = 0;
                enter(M_HOLD);
            end else begin
                m_err = 1'b1;
            end
        end else begin
            case (m_st)
                M_HOLD: if (m_t - m_t0 >= HOLD_CYC) enter(M_WAIT);
                M_WAIT: begin
                    since = (m_last0 > m_t0) ? m_last0 : m_t0;
                    if (m_t - since >= STABLE) enter(M_RUN);
                    else if (m_t - m_t0 >= TIMEOUT) begin
                        if (m_retries < MAX_RETRIES) begin
                            m_retries++;
                            enter(M_HOLD);
                        end else begin
                            enter(M_FAIL);
                        end
                    end
                end
                M_RUN: if (!ls && !m_prev_ls) begin
                    m_lost = 1'b1;
                    m_retries = 0;
                    enter(M_HOLD);
                end
                default: ;
            endcase
        end
        m_prev_ls = ls;
    endtask

    // ---------------- scoreboard / observers ----------------
    logic [1:0] prev_dbg;
    int         prev_mst;
    logic       clk_ok_prev, pll_reset_prev;
    int         rise_cyc, reset_hi_cnt, lost_cnt, hold_rises;

    task automatic compare_all();
        check("pll_reset",      32'(pll_reset),      32'(m_st == M_HOLD || m_st == M_FAIL));
        check("clk_ok",         32'(clk_ok),         32'(m_st == M_RUN));
        check("mode_req_ready", 32'(mode_req_ready), 32'(m_st == M_RUN || m_st == M_FAIL));
        check("fail",           32'(fail),           32'(m_st == M_FAIL));
        check("lost_lock",      32'(lost_lock),      32'(m_lost));
        check("req_err",        32'(req_err),        32'(m_err));
        check("cur_mode",       32'(cur_mode),       32'(m_mode));
        check("selects",        32'({idsel, fbdsel, odsel}), 32'(exp_sel(m_mode)));
        check("state_change",   32'(dbg_state != prev_dbg),  32'(m_st != prev_mst));
        prev_dbg = dbg_state;
        prev_mst = m_st;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        if (clk_ok && !clk_ok_prev) rise_cyc = m_t;
        if (pll_reset) reset_hi_cnt++;
        if (lost_lock) lost_cnt++;
        if (pll_reset && !pll_reset_prev && !fail) hold_rises++;
        clk_ok_prev    = clk_ok;
        pll_reset_prev = pll_reset;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_req(input int m);
        mode_req       = MODE_W'(m);
        mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
    endtask

    task automatic wait_clk_ok(input string tag, input int budget);
        int n = 0;
        while (!clk_ok && n < budget) begin
            step();
            n++;
        end
        check({tag, "_clk_ok"}, 32'(clk_ok), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset),      32'd1);
        check({tag, "_clk_ok"},    32'(clk_ok),         32'd0);
        check({tag, "_fail"},      32'(fail),           32'd0);
        check({tag, "_lost"},      32'(lost_lock),      32'd0);
        check({tag, "_req_err"},   32'(req_err),        32'd0);
        check({tag, "_ready"},     32'(mode_req_ready), 32'd0);
        check({tag, "_cur_mode"},  32'(cur_mode),       32'd0);
        check({tag, "_selects"},   32'({idsel, fbdsel, odsel}), 32'(exp_sel(0)));
    endtask

    // Asserts reset between edges, checks the asynchronous return to reset
    // values, then releases away from the clock edge.
    task automatic do_reset(input string tag);
        reset_n        = 1'b0;
        mode_req_valid = 1'b0;
        #1;
        check_reset_vals(tag);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        prev_dbg       = dbg_state;
        prev_mst       = M_HOLD;
        clk_ok_prev    = clk_ok;
        pll_reset_prev = pll_reset;
        reset_hi_cnt   = pll_reset ? 1 : 0;
        lost_cnt       = 0;
        hold_rises     = 0;
        rise_cyc       = -1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int burst;
        @(posedge clk);
        #1;
        do_reset("por");

        // Bring-up: lock rises in cycle 10, clk_ok expected in cycle 20.
        pll_lock = 1'b0;
        run(10);
        pll_lock = 1'b1;
        wait_clk_ok("bringup", 40);
        check("bringup_rise_cycle", 32'(rise_cyc), 32'd20);
        check("bringup_reset_cycles", 32'(reset_hi_cnt), 32'(HOLD_CYC));
        run($urandom_range(3, 10));

        // Mode switch to 1.
        send_req(1);
        check("sw_clk_ok",    32'(clk_ok),    32'd0);
        check("sw_pll_reset", 32'(pll_reset), 32'd1);
        check("sw_cur_mode",  32'(cur_mode),  32'd1);
        check("sw_selects",   32'({idsel, fbdsel, odsel}), 32'(exp_sel(1)));
        wait_clk_ok("sw", HOLD_CYC + STABLE + 10);
        run($urandom_range(2, 6));

        // Single-cycle dropout is filtered.
        lost_cnt = 0;
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        run(8);
        check("glitch1_lost_cnt", 32'(lost_cnt), 32'd0);
        check("glitch1_clk_ok",   32'(clk_ok),   32'd1);

        // Three-cycle dropout loses lock once, mode kept.
        lost_cnt = 0;
        pll_lock = 1'b0;
        run(3);
        pll_lock = 1'b1;
        run(4);
        check("glitch3_lost_cnt", 32'(lost_cnt), 32'd1);
        check("glitch3_selects",  32'({idsel, fbdsel, odsel}), 32'(exp_sel(1)));
        wait_clk_ok("glitch3", HOLD_CYC + STABLE + 10);
        run(3);

        // Timeout and retries until FAIL.
        hold_rises = 0;
        pll_lock = 1'b0;
        n = 0;
        while (!fail && n < 400) begin
            step();
            n++;
        end
        check("tmo_hold_pulses", 32'(hold_rises),     32'(MAX_RETRIES + 1));
        check("tmo_fail",        32'(fail),           32'd1);
        run(5);
        check("tmo_pll_reset",   32'(pll_reset),      32'd1);
        check("tmo_ready",       32'(mode_req_ready), 32'd1);
        send_req(2);
        check("fail_cleared",    32'(fail),           32'd0);
        check("fail_cur_mode",   32'(cur_mode),       32'd2);
        pll_lock = 1'b1;
        wait_clk_ok("recover", HOLD_CYC + STABLE + 10);

        // Out-of-range request.
        send_req(3);
        check("oor_req_err",  32'(req_err),  32'd1);
        check("oor_cur_mode", 32'(cur_mode), 32'd2);
        check("oor_clk_ok",   32'(clk_ok),   32'd1);
        step();
        check("oor_req_err_pulse", 32'(req_err), 32'd0);

        // Request on the same edge the lock loss would be detected.
        lost_cnt = 0;
        pll_lock = 1'b0;
        run(3);
        send_req(0);
        check("simul_lost",      32'(lost_lock), 32'd0);
        check("simul_cur_mode",  32'(cur_mode),  32'd0);
        check("simul_pll_reset", 32'(pll_reset), 32'd1);
        pll_lock = 1'b1;
        wait_clk_ok("simul", HOLD_CYC + STABLE + 10);

        // Asynchronous reset mid-operation from a non-default mode.
        send_req(2);
        wait_clk_ok("pre_reset", HOLD_CYC + STABLE + 10);
        run(2);
        do_reset("midop");

        // Randomized lock bursts and requests.
        burst = 0;
        for (int c = 0; c < 800; c++) begin
            if (burst == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    pll_lock = 1'b1;
                    burst = $urandom_range(5, 40);
                end else begin
                    pll_lock = 1'b0;
                    burst = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 250) : $urandom_range(1, 5);
                end
            end
            burst--;
            mode_req       = MODE_W'($urandom_range(0, 3));
            mode_req_valid = ($urandom_range(0, 9) == 0);
            step();
        end
        mode_req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
        $fatal(1);
    end

endmodule

// File: doc/pll_mode_ctrl.md
# pll_mode_ctrl

Run-time controller for the HDMI rPLL. It drives the PLL's dynamic IDSEL/FBDSEL/ODSEL inputs from a table of video clock modes, sequences PLL reset and lock qualification, and retries or flags failure on lock timeout. Downstream logic gets a single qualified `clk_ok`. It sits between the video-mode register block and the rPLL instance and runs on the 27 MHz crystal clock.

## Interface
- `NUM_MODES`, 4: entries in the mode table; `MODE_W = $clog2(NUM_MODES)`.
- `DEFAULT_MODE`, 0: mode loaded out of reset.
- `RESET_HOLD_CYC`, 16: cycles `pll_reset` is held high per attempt.
- `LOCK_STABLE_CYC`, 1024: consecutive synchronised lock-high cycles required before `clk_ok`.
- `LOCK_TIMEOUT_CYC`, 1048576: cycles allowed in WAIT_LOCK before a retry.
- `MAX_RETRIES`, 3: retries after the first attempt before FAIL.
- `clk` in 1: 27 MHz reference clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode_req` in MODE_W: requested mode index.
- `mode_req_valid` in 1: request strobe.
- `mode_req_ready` out 1: high in RUN and FAIL only.
- `pll_lock` in 1: asynchronous LOCK from rPLL.
- `pll_reset` out 1: to rPLL RESET.
- `idsel`, `fbdsel`, `odsel` out 6 each: rPLL dynamic selects.
- `cur_mode` out MODE_W: mode currently programmed.
- `clk_ok` out 1: PLL output qualified.
- `lost_lock` out 1: one-cycle pulse on loss of lock in RUN.
- `req_err` out 1: one-cycle pulse on an out-of-range request.
- `fail` out 1: retries exhausted.

## Operation
- The `pll_lock` input passes through a 2-FF synchroniser to produce `lock_s`.
- States are HOLD, WAIT_LOCK, RUN and FAIL.
- **Reset values:**
  - State is HOLD. `pll_reset` is 1.
  - `cur_mode` is DEFAULT_MODE, and the selects come from the table entry for DEFAULT_MODE.
  - `clk_ok`, `fail`, `lost_lock`, `req_err` and `mode_req_ready` are 0. The retry count is 0.
- **HOLD:**
  - `pll_reset` is 1. Count RESET_HOLD_CYC cycles.
  - At terminal count, go to WAIT_LOCK with `pll_reset` at 0, and clear the stable and timeout counters.
- **WAIT_LOCK:**
  - The stable counter increments while `lock_s` is 1 and clears on 0.
  - When it reaches LOCK_STABLE_CYC, go to RUN.
  - When the timeout counter reaches LOCK_TIMEOUT_CYC:
    - If retries < MAX_RETRIES, increment retries and go to HOLD.
    - Otherwise go to FAIL.
- **RUN:**
  - `clk_ok` is 1.
  - If `lock_s` is 0 for 2 consecutive cycles: pulse `lost_lock`, clear retries, go to HOLD (same mode).
  - A single-cycle low is ignored.
- **Request acceptance:** a request is accepted when `mode_req_valid && mode_req_ready`.
  - If `mode_req < NUM_MODES`: latch `cur_mode` and the selects, clear retries and `fail`, go to HOLD.
  - Otherwise pulse `req_err` and keep the state unchanged.
- **Simultaneous events in RUN:** a valid request and a lock loss in the same cycle are resolved in favour of the request, and `lost_lock` is not pulsed.
- **FAIL:** `pll_reset` is 1 and `fail` is 1 until a valid request is accepted.
- **Select stability:** the selects change only on the edge that enters HOLD, so they are never altered while `pll_reset` is 0.
- **Reset mid-operation:** asserting `reset_n` at any point returns every output to its reset value immediately, without waiting for a clock edge.

## Timing
- All outputs are registered.
- **Request path:** the request is accepted at edge N. At that edge, `clk_ok` falls, `pll_reset` rises, and the selects and `cur_mode` update.
- **HOLD duration:** `pll_reset` is high for exactly RESET_HOLD_CYC cycles per attempt.
- **Lock to `clk_ok`:** `pll_lock` rising reaches `lock_s` after 2 cycles. `clk_ok` rises LOCK_STABLE_CYC cycles after that.
- **Lock loss:** from `pll_lock` falling, `clk_ok` falls after 2 cycles of synchroniser delay plus 2 cycles of filter, with `lost_lock` pulsing in the same cycle.
- **Counter widths:** counters are sized with `$clog2` of their limit + 1. They saturate and never wrap.

## Structure
- **Package `pll_mode_pkg`:**
  - Mode struct {idsel, fbdsel, odsel}, each 6 bits, holding values already in the rPLL dynamic-select encoding.
  - Mode table constants:
    - Mode 0: 371.25 MHz (÷4, ×55, /2).
    - Mode 1: 126 MHz (÷3, ×14, /4).
    - Mode 2: 270 MHz (÷1, ×10, /2).
    - Mode 3: 135 MHz (÷1, ×5, /4).
  - State enum.
- **Sub-module `cdc_sync2`:** 2-flop synchroniser with asynchronous active-low reset to 0.

## Test plan
Simulation parameters: RESET_HOLD_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, MAX_RETRIES=2.

- **Reset bring-up:** release `reset_n`, then raise `pll_lock` at cycle 10.
  - `pll_reset` is high for cycles 0–3; selects match mode 0.
  - `clk_ok` rises at cycle 20 (10 + 2 synchroniser + 8 stable).
- **Mode switch:** in RUN, send `mode_req`=1.
  - Same edge: `clk_ok` 0, `pll_reset` 1, selects change to mode 1.
  - `cur_mode`=1, and `clk_ok` returns after relock.
- **Lock glitch:**
  - Drop `pll_lock` for 1 cycle: no `lost_lock`, `clk_ok` stays 1.
  - Drop it for 3 cycles: `lost_lock` pulses once, state enters HOLD, selects unchanged.
- **Timeout and fail:** keep `pll_lock`=0.
  - Exactly 3 HOLD pulses occur, then `fail`=1 with `pll_reset` stuck at 1 and `mode_req_ready`=1.
  - A request for mode 2 clears `fail`.
- **Out-of-range request:** `mode_req`=3 with NUM_MODES=3.
  - `req_err` pulses for 1 cycle; state, `cur_mode` and `clk_ok` are unchanged.
- **Simultaneous request and lock loss in RUN:** request is taken, `lost_lock` stays 0, new mode is programmed.
